// File: rtl/unit_test_result_collector_pkg.sv
// unit_test_collector_pkg: shared types and helpers for the unit-test result
// collector. Holds the sequencer state encoding, the first-fail channel width
// helper and the saturating add used by the pass/fail counters.
package unit_test_collector_pkg;

  // Test sequencer states: idle, accepting traffic, draining, verdict held.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Wide working type for saturating arithmetic; counters up to 63 bits fit.
  localparam int SAT_W = 64;
  typedef logic [SAT_W-1:0] sat_t;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // a + inc clamped to the all-ones value of a w-bit counter (w < SAT_W).
  function automatic sat_t sat_add(input sat_t a, input sat_t inc, input int unsigned w);
    sat_t max_v;
    sat_t sum;
    max_v = (sat_t'(1) << w) - sat_t'(1);
    sum   = a + inc;
    return (sum > max_v) ? max_v : sum;
  endfunction

endpackage

// File: rtl/unit_test_result_collector_exp_fifo.sv
// unit_test_exp_fifo: expected-value FIFO for one compare channel.
// Pointers carry one extra wrap bit so full and empty are distinguishable
// without an occupancy counter. dout always shows the current head; a pop in
// the same cycle as a push only ever sees entries written in earlier cycles.
// clr empties the FIFO synchronously and overrides push/pop.
module unit_test_exp_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t              wr_ptr_q, wr_ptr_d;
  ptr_t              rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];
  assign do_push = push && !full && !clr;
  assign do_pop  = pop && !empty && !clr;

  // Next-pointer logic: clear wins, otherwise advance on accepted push/pop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
    end
  end

  // Pointer registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    // NOTE: the storage array is deliberately not reset; empty/full come from the pointers alone.
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/unit_test_result_collector.sv
// unit_test_result_collector: multi-channel in-order expected/actual checker.
// Each channel buffers expected values in a FIFO; every accepted actual pops
// the head and is compared against it. Pass/fail counts saturate, the first
// failure is captured, and a RUN -> DRAIN -> DONE sequence with an optional
// drain timeout produces the final verdict.
// Optional build macro: UNIT_TEST_COLLECTOR_MASK_EN adds an act_mask input
// whose set bits select which bits take part in the compare.
module unit_test_result_collector
  import unit_test_collector_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = 16,
  parameter int TMO_W  = 20
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     end_of_test,
  input  logic [TMO_W-1:0]         timeout_cycles,
  input  logic [NUM_CH-1:0]        exp_valid,
  output logic [NUM_CH-1:0]        exp_ready,
  input  logic [NUM_CH*DATA_W-1:0] exp_data,
  input  logic [NUM_CH-1:0]        act_valid,
  output logic [NUM_CH-1:0]        act_ready,
  input  logic [NUM_CH*DATA_W-1:0] act_data,
`ifdef UNIT_TEST_COLLECTOR_MASK_EN
  input  logic [NUM_CH*DATA_W-1:0] act_mask,
`endif
  output logic                     busy,
  output logic                     done,
  output logic                     passed,
  output logic [CNT_W-1:0]         pass_cnt,
  output logic [CNT_W-1:0]         fail_cnt,
  output logic                     unexpected,
  output logic                     timed_out,
  output logic                     ff_valid,
  output logic [ch_w(NUM_CH)-1:0]  ff_ch,
  output logic [DATA_W-1:0]        ff_exp,
  output logic [DATA_W-1:0]        ff_act
);

  localparam int CH_W = ch_w(NUM_CH);

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [TMO_W-1:0] tmo_t;

  // Sequencer and result registers.
  state_e            state_q, state_d;
  cnt_t              pass_cnt_q, pass_cnt_d;
  cnt_t              fail_cnt_q, fail_cnt_d;
  tmo_t              drain_cnt_q, drain_cnt_d;
  logic              unexpected_q, unexpected_d;
  logic              timed_out_q, timed_out_d;
  logic              ff_valid_q, ff_valid_d;
  logic [CH_W-1:0]   ff_ch_q, ff_ch_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_act_q, ff_act_d;

  // Per-channel handshake and compare results.
  logic [NUM_CH-1:0] fifo_clr;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] act_hs;
  logic [NUM_CH-1:0] match;
  logic [NUM_CH-1:0] fail;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] full;
  logic [DATA_W-1:0] head [NUM_CH];
  logic              clr_all;

  assign fifo_clr = {NUM_CH{clr_all}};

  // One expected FIFO per channel.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    unit_test_exp_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (fifo_clr[g]),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (exp_data[g*DATA_W +: DATA_W]),
      .dout  (head[g]),
      .empty (empty[g]),
      .full  (full[g])
    );
  end

  // Ready generation: pushes only in RUN, actuals accepted in RUN and DRAIN.
  always_comb begin
    exp_ready = '0;
    act_ready = '0;
    if (state_q == ST_RUN) begin
      exp_ready = ~full;
      act_ready = '1;
    end else if (state_q == ST_DRAIN) begin
      act_ready = '1;
    end
  end

  // Per-channel handshakes and compare; an actual on an empty FIFO is a fail.
  always_comb begin
    push   = '0;
    pop    = '0;
    act_hs = '0;
    match  = '0;
    fail   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i]   = exp_valid[i] & exp_ready[i];
      act_hs[i] = act_valid[i] & act_ready[i];
      pop[i]    = act_hs[i] & ~empty[i];
`ifdef UNIT_TEST_COLLECTOR_MASK_EN
      match[i]  = pop[i] & (((head[i] ^ act_data[i*DATA_W +: DATA_W]) &
                             act_mask[i*DATA_W +: DATA_W]) == '0);
`else
      match[i]  = pop[i] & (head[i] == act_data[i*DATA_W +: DATA_W]);
`endif
      fail[i]   = act_hs[i] & ~match[i];
    end
  end

  // Sequencer next state plus counter, sticky-flag and first-fail updates.
  always_comb begin
    state_d      = state_q;
    drain_cnt_d  = drain_cnt_q;
    timed_out_d  = timed_out_q;
    clr_all      = 1'b0;
    pass_cnt_d   = cnt_t'(sat_add(sat_t'(pass_cnt_q), sat_t'($countones(match)), CNT_W));
    fail_cnt_d   = cnt_t'(sat_add(sat_t'(fail_cnt_q), sat_t'($countones(fail)), CNT_W));
    unexpected_d = unexpected_q | (|(act_hs & empty));
    ff_valid_d   = ff_valid_q;
    ff_ch_d      = ff_ch_q;
    ff_exp_d     = ff_exp_q;
    ff_act_d     = ff_act_q;

    // Capture only on the first failing cycle; descending scan lets the lowest index win.
    if (!ff_valid_q && (|fail)) begin
      ff_valid_d = 1'b1;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (fail[i]) begin
          ff_ch_d  = CH_W'(i);
          ff_exp_d = empty[i] ? '0 : head[i];
          ff_act_d = act_data[i*DATA_W +: DATA_W];
        end
      end
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d      = ST_RUN;
          clr_all      = 1'b1;
          pass_cnt_d   = '0;
          fail_cnt_d   = '0;
          unexpected_d = 1'b0;
          timed_out_d  = 1'b0;
          ff_valid_d   = 1'b0;
          ff_ch_d      = '0;
          ff_exp_d     = '0;
          ff_act_d     = '0;
        end
      end
      ST_RUN: begin
        if (end_of_test) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = '0;
        end
      end
      ST_DRAIN: begin
        // Emptiness is judged on the registered FIFO pointers and wins over the timeout.
        if (&empty) begin
          state_d = ST_DONE;
        end else if ((timeout_cycles != '0) && (drain_cnt_q == timeout_cycles - tmo_t'(1))) begin
          state_d     = ST_DONE;
          timed_out_d = 1'b1;
        end else begin
          drain_cnt_d = drain_cnt_q + tmo_t'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and result registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      drain_cnt_q  <= '0;
      unexpected_q <= 1'b0;
      timed_out_q  <= 1'b0;
      ff_valid_q   <= 1'b0;
      ff_ch_q      <= '0;
      ff_exp_q     <= '0;
      ff_act_q     <= '0;
    end else begin
      state_q      <= state_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      drain_cnt_q  <= drain_cnt_d;
      unexpected_q <= unexpected_d;
      timed_out_q  <= timed_out_d;
      ff_valid_q   <= ff_valid_d;
      ff_ch_q      <= ff_ch_d;
      ff_exp_q     <= ff_exp_d;
      ff_act_q     <= ff_act_d;
    end
  end

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign passed     = done && (fail_cnt_q == '0) && !unexpected_q && !timed_out_q &&
                      (pass_cnt_q != '0);
  assign pass_cnt   = pass_cnt_q;
  assign fail_cnt   = fail_cnt_q;
  assign unexpected = unexpected_q;
  assign timed_out  = timed_out_q;
  assign ff_valid   = ff_valid_q;
  assign ff_ch      = ff_ch_q;
  assign ff_exp     = ff_exp_q;
  assign ff_act     = ff_act_q;

endmodule
